vga_draw_scheduler: RTL and testbench
=====================================

Name: vga_draw_scheduler

Overview:
- Sequences the three pixel-drawing engines of the Tetris display and shares the single VGA pixel write port between them.
- The engines are: full-screen clear, 10x20 board redraw, and active-piece overlay.
- Jobs are launched only on a frame tick, in priority order clear > board > piece. Each engine's pixel stream is muxed onto oX/oY/oColour/oPlot.
- Sits between the game logic (dirty flags) and the VGA adapter.

Parameters:
- FRAME_CYCLES, 833333, clock cycles per frame tick (50 MHz / 60 Hz).
- FRAME_W, 20, width of frame counter; must hold FRAME_CYCLES-1.
- TIMEOUT_CYCLES, 65535, max cycles a job may run before abort.
- TMO_W, 16, width of watchdog counter.

Ports:
- iClock  in  1  system clock
- iResetn  in  1  asynchronous active-low reset
- iBlack  in  1  level; request full-screen clear
- iBoardDirty  in  1  1-cycle pulse; board contents changed
- iPieceDirty  in  1  1-cycle pulse; active piece moved/rotated
- oClearStart  out  1  1-cycle start pulse to clear engine
- iClearDone  in  1  1-cycle done pulse from clear engine
- iClearX/iClearY/iClearColour/iClearPlot  in  8/7/3/1  clear engine pixel stream
- oBoardStart  out  1  start pulse to board engine
- iBoardDone  in  1  done pulse from board engine
- iBoardX/iBoardY/iBoardColour/iBoardPlot  in  8/7/3/1  board engine pixel stream
- oPieceStart  out  1  start pulse to piece engine
- iPieceDone  in  1  done pulse from piece engine
- iPieceX/iPieceY/iPieceColour/iPiecePlot  in  8/7/3/1  piece engine pixel stream
- oX  out  8  VGA x
- oY  out  7  VGA y
- oColour  out  3  VGA colour
- oPlot  out  1  VGA write enable
- oBusy  out  1  high while any job is active
- oFrameTick  out  1  1-cycle pulse per frame
- oTimeout  out  1  sticky; a job was aborted

Behaviour:

Reset:
- Clock is iClock. Reset is iResetn: asynchronous, active-low.
- Reset drives every output to 0 and the state to IDLE.
- Reset clears the frame counter, the watchdog and all pending flags, except board_pend, which resets to 1 so the first frame draws the board.

Frame counter:
- Free-running, counts 0..FRAME_CYCLES-1 and then wraps.
- oFrameTick=1 for exactly the cycle the count equals FRAME_CYCLES-1.

Pending flags (clr_pend, board_pend, piece_pend):
- Set: clr_pend every cycle iBlack=1; board_pend on iBoardDirty; piece_pend on iPieceDirty.
- Completing clear sets board_pend. Completing board sets piece_pend.
- Clear: a flag clears when its job completes or aborts.
- If a set and a clear land on the same cycle, set wins.

States: IDLE, CLEAR, BOARD, PIECE.
- IDLE: on a cycle with oFrameTick=1, move to the highest-priority pending job. If nothing is pending, stay in IDLE. Pending flags alone never start a job outside a tick.
- Job state, first cycle: the matching oXStart=1 for exactly that one cycle. The watchdog loads 0.
- Job state, subsequent cycles: the watchdog increments every cycle.
- Job completes (done seen): clear that job's flag. If any flag is still pending (including one set this cycle), go directly to the highest-priority pending job next cycle, with no wait for a tick. Otherwise go to IDLE.
- Watchdog: if it reaches TIMEOUT_CYCLES-1 without done, abort. Clear that job's flag, set oTimeout (held until reset), go to IDLE.
- Done inputs from non-active engines are ignored. A done on the same cycle as the start pulse is ignored.

Pixel mux:
- oX/oY/oColour/oPlot are registered copies of the active engine's inputs, 1-cycle latency.
- In IDLE, and on the transition cycle out of a job, oPlot=0 and oX/oY/oColour hold their last values.
- oBusy=1 in CLEAR, BOARD and PIECE; 0 in IDLE.

Reset mid-job:
- Outputs and start pulses drop immediately; the aborted job is not resumed.
- Only board_pend=1 survives.
- Engines must tolerate losing their job without a done.

Test Plan:
- FRAME_CYCLES=100. Release reset -> all outputs 0; at cycle 99 oFrameTick=1; next cycle oBoardStart=1 for 1 cycle, oBusy=1. Board done pulse -> PIECE entered next cycle with oPieceStart=1 (piece_pend set by board completion). Piece done -> IDLE, oBusy=0.
- iBlack=1 for 5 cycles mid-frame, then iBoardDirty pulse -> nothing starts until the tick. Tick -> CLEAR, then BOARD, then PIECE back-to-back, each start 1 cycle after the previous done.
- In BOARD, drive iBoardX=55, iBoardY=12, iBoardColour=3'b001, iBoardPlot=1 at cycle t -> oX=55, oY=12, oColour=1, oPlot=1 at t+1. Piece-engine inputs toggling meanwhile must not appear on the outputs.
- iPieceDirty during BOARD, on the same cycle as iBoardDone -> PIECE entered next cycle. After it completes, piece_pend=0 and the scheduler goes IDLE.
- TIMEOUT_CYCLES=20, no iClearDone -> abort 20 cycles after the start cycle; oTimeout=1 and stays 1; the next tick dispatches BOARD normally.
- Assert iResetn=0 mid-BOARD asynchronously (between edges) -> oPlot, oBusy and the start outputs go 0 immediately. After release, the first tick starts BOARD.

Source files
------------

// File: rtl/vga_draw_scheduler_if.sv
// Signal bundle between the draw scheduler, its three pixel engines,
// the game logic dirty flags and the VGA adapter.
interface vga_draw_scheduler_if;
  logic       iBlack;
  logic       iBoardDirty;
  logic       iPieceDirty;

  logic       oClearStart;
  logic       iClearDone;
  logic [7:0] iClearX;
  logic [6:0] iClearY;
  logic [2:0] iClearColour;
  logic       iClearPlot;

  logic       oBoardStart;
  logic       iBoardDone;
  logic [7:0] iBoardX;
  logic [6:0] iBoardY;
  logic [2:0] iBoardColour;
  logic       iBoardPlot;

  logic       oPieceStart;
  logic       iPieceDone;
  logic [7:0] iPieceX;
  logic [6:0] iPieceY;
  logic [2:0] iPieceColour;
  logic       iPiecePlot;

  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oPlot;
  logic       oBusy;
  logic       oFrameTick;
  logic       oTimeout;

  modport master (
    input  iBlack, iBoardDirty, iPieceDirty,
    input  iClearDone, iClearX, iClearY, iClearColour, iClearPlot,
    input  iBoardDone, iBoardX, iBoardY, iBoardColour, iBoardPlot,
    input  iPieceDone, iPieceX, iPieceY, iPieceColour, iPiecePlot,
    output oClearStart, oBoardStart, oPieceStart,
    output oX, oY, oColour, oPlot, oBusy, oFrameTick, oTimeout
  );

  modport slave (
    output iBlack, iBoardDirty, iPieceDirty,
    output iClearDone, iClearX, iClearY, iClearColour, iClearPlot,
    output iBoardDone, iBoardX, iBoardY, iBoardColour, iBoardPlot,
    output iPieceDone, iPieceX, iPieceY, iPieceColour, iPiecePlot,
    input  oClearStart, oBoardStart, oPieceStart,
    input  oX, oY, oColour, oPlot, oBusy, oFrameTick, oTimeout
  );
endinterface

// File: rtl/vga_draw_scheduler.sv
// Frame-tick driven sequencer for the clear / board / piece draw engines,
// sharing one registered VGA pixel write port between them.
module vga_draw_scheduler #(
  parameter int FRAME_CYCLES   = 833333,
  parameter int FRAME_W        = 20,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMO_W          = 16
) (
  input  logic                 iClock,
  input  logic                 iResetn,
  vga_draw_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    BOARD = 2'd2,
    PIECE = 2'd3
  } state_t;

  state_t             state_reg, state_next, pick_state;
  logic               first_reg;
  logic [FRAME_W-1:0] frame_cnt_reg;
  logic [TMO_W-1:0]   wdog_reg;
  logic [2:0]         pend_reg, pend_set, pend_clr, pend_next;
  logic               timeout_reg;
  logic [7:0]         x_reg;
  logic [6:0]         y_reg;
  logic [2:0]         colour_reg;
  logic               plot_reg;

  logic               frame_tick, busy, abort, leaving, entering;
  logic [2:0]         eng_done, eng_plot, eng_active, done_ok;
  logic [7:0]         eng_x      [3];
  logic [6:0]         eng_y      [3];
  logic [2:0]         eng_colour [3];
  logic [7:0]         sel_x;
  logic [6:0]         sel_y;
  logic [2:0]         sel_colour;
  logic               sel_plot;

  // Engine index 0 = clear, 1 = board, 2 = piece; matches state encoding minus one.
  assign eng_done      = {bus.iPieceDone, bus.iBoardDone, bus.iClearDone};
  assign eng_plot      = {bus.iPiecePlot, bus.iBoardPlot, bus.iClearPlot};
  assign eng_x[0]      = bus.iClearX;
  assign eng_x[1]      = bus.iBoardX;
  assign eng_x[2]      = bus.iPieceX;
  assign eng_y[0]      = bus.iClearY;
  assign eng_y[1]      = bus.iBoardY;
  assign eng_y[2]      = bus.iPieceY;
  assign eng_colour[0] = bus.iClearColour;
  assign eng_colour[1] = bus.iBoardColour;
  assign eng_colour[2] = bus.iPieceColour;

  assign frame_tick = (frame_cnt_reg == FRAME_W'(FRAME_CYCLES - 1));
  assign busy       = (state_reg != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_eng
      assign eng_active[gi] = (state_reg == state_t'(2'(gi + 1)));
      // A done arriving alongside the start pulse belongs to no job yet.
      assign done_ok[gi]    = eng_active[gi] & eng_done[gi] & ~first_reg;
      assign pend_clr[gi]   = eng_active[gi] & leaving;
    end
  endgenerate

  assign abort    = busy & ~(|done_ok) & (wdog_reg == TMO_W'(TIMEOUT_CYCLES - 1));
  assign leaving  = (|done_ok) | abort;
  assign pend_set = {bus.iPieceDirty | done_ok[1], bus.iBoardDirty | done_ok[0], bus.iBlack};
  assign pend_next = pend_set | (pend_reg & ~pend_clr);
  assign entering = (state_next != IDLE) & (~busy | leaving);

  always_comb begin
    pick_state = IDLE;
    if (pend_next[0])      pick_state = CLEAR;
    else if (pend_next[1]) pick_state = BOARD;
    else if (pend_next[2]) pick_state = PIECE;
  end

  // FSM: state register
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_reg <= IDLE;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      first_reg <= entering;
    end
  end

  // FSM: next state; an abort always returns to IDLE even with work pending
  always_comb begin
    state_next = state_reg;
    if (state_reg == IDLE) begin
      if (frame_tick) state_next = pick_state;
    end else if (abort) begin
      state_next = IDLE;
    end else if (|done_ok) begin
      state_next = pick_state;
    end
  end

  // FSM: outputs
  always_comb begin
    bus.oClearStart = 1'b0;
    bus.oBoardStart = 1'b0;
    bus.oPieceStart = 1'b0;
    bus.oBusy       = 1'b0;
    case (state_reg)
      CLEAR: begin bus.oBusy = 1'b1; bus.oClearStart = first_reg; end
      BOARD: begin bus.oBusy = 1'b1; bus.oBoardStart = first_reg; end
      PIECE: begin bus.oBusy = 1'b1; bus.oPieceStart = first_reg; end
      default: ;
    endcase
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      frame_cnt_reg <= '0;
      wdog_reg      <= '0;
      pend_reg      <= 3'b010;
      timeout_reg   <= 1'b0;
    end else begin
      frame_cnt_reg <= frame_tick ? '0 : frame_cnt_reg + FRAME_W'(1);
      if (entering)  wdog_reg <= '0;
      else if (busy) wdog_reg <= wdog_reg + TMO_W'(1);
      pend_reg      <= pend_next;
      timeout_reg   <= timeout_reg | abort;
    end
  end

  always_comb begin
    sel_x      = eng_x[0];
    sel_y      = eng_y[0];
    sel_colour = eng_colour[0];
    sel_plot   = eng_plot[0];
    case (state_reg)
      BOARD: begin
        sel_x = eng_x[1]; sel_y = eng_y[1]; sel_colour = eng_colour[1]; sel_plot = eng_plot[1];
      end
      PIECE: begin
        sel_x = eng_x[2]; sel_y = eng_y[2]; sel_colour = eng_colour[2]; sel_plot = eng_plot[2];
      end
      default: ;
    endcase
  end

  // The cycle a job ends is not forwarded, so a late pixel never leaks out.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      x_reg      <= '0;
      y_reg      <= '0;
      colour_reg <= '0;
      plot_reg   <= 1'b0;
    end else if (busy && !leaving) begin
      x_reg      <= sel_x;
      y_reg      <= sel_y;
      colour_reg <= sel_colour;
      plot_reg   <= sel_plot;
    end else begin
      plot_reg   <= 1'b0;
    end
  end

  assign bus.oX         = x_reg;
  assign bus.oY         = y_reg;
  assign bus.oColour    = colour_reg;
  assign bus.oPlot      = plot_reg;
  assign bus.oFrameTick = frame_tick;
  assign bus.oTimeout   = timeout_reg;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Directed bench for vga_draw_scheduler: a cycle-level job model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_vga_draw_scheduler;
  localparam int FC  = 100;
  localparam int TMO = 20;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   tog_piece = 0;

  vga_draw_scheduler_if bus ();

  vga_draw_scheduler #(
    .FRAME_CYCLES  (FC),
    .FRAME_W       (7),
    .TIMEOUT_CYCLES(TMO),
    .TMO_W         (5)
  ) dut (
    .iClock (clk),
    .iResetn(rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Model: m_job 0 none / 1 clear / 2 board / 3 piece, m_age = cycles since its start.
  int       m_job, m_age, m_frame, m_to, m_x, m_y, m_c, m_plot;
  bit [2:0] m_pend;
  bit       m_ready = 0;

  task automatic m_reset();
    m_job = 0; m_age = 0; m_frame = 0; m_to = 0;
    m_x = 0; m_y = 0; m_c = 0; m_plot = 0;
    m_pend = 3'b010;
    m_ready = 1;
  endtask

  task automatic m_step();
    int ed, ex, ey, ec, ep, nj;
    bit tick, done_now, abort_now, started;
    bit [2:0] np;
    tick = (m_frame == FC - 1);
    case (m_job)
      1: begin ed = int'(bus.iClearDone); ex = int'(bus.iClearX); ey = int'(bus.iClearY);
               ec = int'(bus.iClearColour); ep = int'(bus.iClearPlot); end
      2: begin ed = int'(bus.iBoardDone); ex = int'(bus.iBoardX); ey = int'(bus.iBoardY);
               ec = int'(bus.iBoardColour); ep = int'(bus.iBoardPlot); end
      3: begin ed = int'(bus.iPieceDone); ex = int'(bus.iPieceX); ey = int'(bus.iPieceY);
               ec = int'(bus.iPieceColour); ep = int'(bus.iPiecePlot); end
      default: begin ed = 0; ex = 0; ey = 0; ec = 0; ep = 0; end
    endcase
    done_now  = (m_job != 0) && (m_age > 0) && (ed != 0);
    abort_now = (m_job != 0) && !done_now && (m_age == TMO - 1);
    np = m_pend;
    if (done_now || abort_now) np[m_job-1] = 1'b0;
    if (bus.iBlack)      np[0] = 1'b1;
    if (bus.iBoardDirty) np[1] = 1'b1;
    if (bus.iPieceDirty) np[2] = 1'b1;
    if (done_now && m_job == 1) np[1] = 1'b1;
    if (done_now && m_job == 2) np[2] = 1'b1;
    nj = m_job;
    if ((m_job == 0 && tick) || done_now) nj = np[0] ? 1 : np[1] ? 2 : np[2] ? 3 : 0;
    else if (abort_now) nj = 0;
    started = (nj != 0) && (m_job == 0 || done_now);
    if (m_job != 0 && !done_now && !abort_now) begin
      m_x = ex; m_y = ey; m_c = ec; m_plot = ep;
    end else begin
      m_plot = 0;
    end
    m_age   = started ? 0 : m_age + 1;
    m_job   = nj;
    m_pend  = np;
    if (abort_now) m_to = 1;
    m_frame = (m_frame + 1) % FC;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_ready) begin
        chk("frame_tick", int'(bus.oFrameTick), int'(m_frame == FC - 1));
        chk("busy",       int'(bus.oBusy),      int'(m_job != 0));
        chk("clear_start", int'(bus.oClearStart), int'(m_job == 1 && m_age == 0));
        chk("board_start", int'(bus.oBoardStart), int'(m_job == 2 && m_age == 0));
        chk("piece_start", int'(bus.oPieceStart), int'(m_job == 3 && m_age == 0));
        chk("timeout", int'(bus.oTimeout), m_to);
        chk("plot",    int'(bus.oPlot),    m_plot);
        chk("x",       int'(bus.oX),       m_x);
        chk("y",       int'(bus.oY),       m_y);
        chk("colour",  int'(bus.oColour),  m_c);
      end
    end
  end

  task automatic step1();
    @(posedge clk);
    #1;
    cyc++;
    if (tog_piece) begin
      bus.iPieceX      = 8'($urandom);
      bus.iPieceY      = 7'($urandom);
      bus.iPieceColour = 3'($urandom);
      bus.iPiecePlot   = 1'($urandom);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) step1();
  endtask

  initial begin
    bus.iBlack = 0; bus.iBoardDirty = 0; bus.iPieceDirty = 0;
    bus.iClearDone = 0; bus.iClearX = 0; bus.iClearY = 0; bus.iClearColour = 0; bus.iClearPlot = 0;
    bus.iBoardDone = 0; bus.iBoardX = 0; bus.iBoardY = 0; bus.iBoardColour = 0; bus.iBoardPlot = 0;
    bus.iPieceDone = 0; bus.iPieceX = 0; bus.iPieceY = 0; bus.iPieceColour = 0; bus.iPiecePlot = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;

    // Power-up: board drawn on first tick, then piece from board completion.
    chk("lit_reset_busy", int'(bus.oBusy), 0);
    chk("lit_reset_plot", int'(bus.oPlot), 0);
    chk("lit_reset_timeout", int'(bus.oTimeout), 0);
    goto(99);  chk("lit_tick99", int'(bus.oFrameTick), 1);
    goto(100); chk("lit_board_start", int'(bus.oBoardStart), 1);
               chk("lit_busy100", int'(bus.oBusy), 1);
    goto(101); chk("lit_board_start_1cyc", int'(bus.oBoardStart), 0);
               bus.iBoardDone = 1;
    goto(102); bus.iBoardDone = 0;
               chk("lit_piece_start", int'(bus.oPieceStart), 1);
               bus.iPieceDone = 1;
    goto(103); bus.iPieceDone = 0; bus.iClearDone = 1;
    goto(104); bus.iClearDone = 0;
               chk("lit_start_done_ignored", int'(bus.oBusy), 1);
               bus.iPieceDone = 1;
    goto(105); bus.iPieceDone = 0;
               chk("lit_idle105", int'(bus.oBusy), 0);

    // Requests mid-frame wait for the tick, then clear/board/piece back-to-back.
    goto(110); bus.iBlack = 1;
    goto(115); bus.iBlack = 0;
    goto(116); bus.iBoardDirty = 1;
    goto(117); bus.iBoardDirty = 0;
    goto(150); chk("lit_no_start_off_tick", int'(bus.oBusy), 0);
    goto(200); chk("lit_clear_start", int'(bus.oClearStart), 1);
    goto(203); bus.iClearDone = 1;
    goto(204); bus.iClearDone = 0;
               chk("lit_board_after_clear", int'(bus.oBoardStart), 1);
    goto(205); tog_piece = 1;
               bus.iBoardX = 8'd55; bus.iBoardY = 7'd12; bus.iBoardColour = 3'b001; bus.iBoardPlot = 1;
    goto(206); chk("lit_px_x", int'(bus.oX), 55);
               chk("lit_px_y", int'(bus.oY), 12);
               chk("lit_px_colour", int'(bus.oColour), 1);
               chk("lit_px_plot", int'(bus.oPlot), 1);
               bus.iBoardX = 8'd77;
    goto(207); bus.iBoardDone = 1; bus.iPieceDirty = 1; bus.iBoardX = 8'd99;
    goto(208); bus.iBoardDone = 0; bus.iPieceDirty = 0; bus.iBoardPlot = 0;
               chk("lit_piece_after_board", int'(bus.oPieceStart), 1);
               chk("lit_exit_plot", int'(bus.oPlot), 0);
               chk("lit_exit_x_hold", int'(bus.oX), 77);
    goto(210); bus.iPieceDone = 1;
    goto(211); bus.iPieceDone = 0; tog_piece = 0;
               bus.iPieceX = 0; bus.iPieceY = 0; bus.iPieceColour = 0; bus.iPiecePlot = 0;
               chk("lit_idle211", int'(bus.oBusy), 0);

    // Watchdog abort of a clear that never finishes.
    goto(220); bus.iBlack = 1;
    goto(221); bus.iBlack = 0;
    goto(300); chk("lit_clear_start300", int'(bus.oClearStart), 1);
    goto(319); chk("lit_busy319", int'(bus.oBusy), 1);
               chk("lit_timeout319", int'(bus.oTimeout), 0);
    goto(320); chk("lit_abort_idle", int'(bus.oBusy), 0);
               chk("lit_timeout320", int'(bus.oTimeout), 1);
    goto(330); bus.iBoardDirty = 1;
    goto(331); bus.iBoardDirty = 0;
    goto(400); chk("lit_board_after_abort", int'(bus.oBoardStart), 1);
               chk("lit_timeout_sticky", int'(bus.oTimeout), 1);
    goto(402); bus.iBoardDone = 1;
    goto(403); bus.iBoardDone = 0;
    goto(405); bus.iPieceDone = 1;
    goto(406); bus.iPieceDone = 0;

    // Asynchronous reset in the middle of a board job.
    goto(410); bus.iBoardDirty = 1;
    goto(411); bus.iBoardDirty = 0;
    goto(500); chk("lit_board_start500", int'(bus.oBoardStart), 1);
    goto(502); bus.iBoardX = 8'd10; bus.iBoardY = 7'd20; bus.iBoardColour = 3'd5; bus.iBoardPlot = 1;
    goto(503); chk("lit_plot503", int'(bus.oPlot), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_plot", int'(bus.oPlot), 0);
    chk("lit_rst_busy", int'(bus.oBusy), 0);
    chk("lit_rst_start", int'(bus.oBoardStart), 0);
    chk("lit_rst_x", int'(bus.oX), 0);
    bus.iBoardPlot = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    goto(99);  chk("lit_tick_after_rst", int'(bus.oFrameTick), 1);
    goto(100); chk("lit_board_after_rst", int'(bus.oBoardStart), 1);
               chk("lit_timeout_cleared", int'(bus.oTimeout), 0);
    goto(101); bus.iBoardDone = 1;
    goto(102); bus.iBoardDone = 0;
               chk("lit_piece_after_rst", int'(bus.oPieceStart), 1);
    goto(103); bus.iPieceDone = 1;
    goto(104); bus.iPieceDone = 0;
    goto(110); chk("lit_final_idle", int'(bus.oBusy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
